m_reg: RTL and testbench



---
 rtl/m_reg.sv | 74 +++++++
 tb/tb_m_reg.sv | 111 +++++++++++
 2 files changed

// File: rtl/m_reg.sv
// ----------------------------------------------------------------------------
// m_reg : multiplicand (M) register of the Booth multiplier datapath.
//
// Captures the multiplicand from the input bus when the controller issues
// LOAD and holds it otherwise. Both M and -M are presented to the adder/
// subtractor stage, so the add-M and subtract-M Booth steps need no extra
// logic there.
//
// Ports
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous active-high reset (priority over ctrl)
//   in     : multiplicand data to capture
//   ctrl   : 1 = LOAD (capture in), 0 = HOLD
//   o      : registered multiplicand M
//   o_neg  : two's-complement negation of o, combinational from o only
//   loaded : high once a LOAD has occurred since the last reset
// ----------------------------------------------------------------------------
module m_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             ctrl,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_neg,
  output logic             loaded
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement negation truncated to WIDTH bits. The most negative
  // value maps onto itself; no overflow indication is produced.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return (~v) + ONE;
  endfunction

  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] m_next_s;
  logic             loaded_r;
  logic             loaded_next_s;

  // Next-state selection: capture on LOAD, otherwise recirculate.
  always_comb begin
    m_next_s      = m_r;
    loaded_next_s = loaded_r;
    if (ctrl) begin
      m_next_s      = in;
      loaded_next_s = 1'b1;
    end else begin
      m_next_s      = m_r;
      loaded_next_s = loaded_r;
    end
  end

  // State register; reset wins over LOAD on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_r      <= ZERO;
      loaded_r <= 1'b0;
    end else begin
      m_r      <= m_next_s;
      loaded_r <= loaded_next_s;
    end
  end

  // o_neg depends only on registered state, so input activity between edges
  // cannot reach any output.
  assign o      = m_r;
  assign o_neg  = twos_neg(m_r);
  assign loaded = loaded_r;

endmodule

// File: tb/tb_m_reg.sv
// ----------------------------------------------------------------------------
// tb_m_reg : self-checking bench for m_reg.
// Directed sequence for reset, load, hold, reload, negation boundaries and
// reset priority, followed by randomized LOAD/HOLD/reset traffic. Expected
// values come from an arithmetic model: M is an integer, -M is (2^W - M) mod
// 2^W, and loaded is a flag set by any LOAD and cleared by reset.
// ----------------------------------------------------------------------------
module tb_m_reg;

  localparam int WIDTH = 4;
  localparam int MOD   = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             ctrl;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] o_neg;
  logic             loaded;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int exp_m      = 0;
  int exp_loaded = 0;

  m_reg #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .ctrl   (ctrl),
    .o      (o),
    .o_neg  (o_neg),
    .loaded (loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".o"},      {28'd0, o},      exp_m);
    check({tag, ".o_neg"},  {28'd0, o_neg},  (MOD - exp_m) % MOD);
    check({tag, ".loaded"}, {31'd0, loaded}, exp_loaded);
  endtask

  // One clock cycle: drive at negedge, update model at posedge, check after
  // the edge, then disturb 'in' mid-cycle and confirm o does not follow.
  task automatic apply(input logic r, input logic c, input logic [WIDTH-1:0] d,
                       input string tag);
    @(negedge clk);
    rst  = r;
    ctrl = c;
    in   = d;
    @(posedge clk);
    if (r) begin
      exp_m      = 0;
      exp_loaded = 0;
    end else if (c) begin
      exp_m      = int'(d);
      exp_loaded = 1;
    end
    #1;
    check_all(tag);
    in = WIDTH'($urandom);
    #1;
    check({tag, ".mid"}, {28'd0, o}, exp_m);
  endtask

  initial begin
    rst  = 1'b1;
    ctrl = 1'b1;
    in   = 4'b0111;

    // directed
    apply(1'b1, 1'b1, 4'b0111, "reset");
    apply(1'b0, 1'b1, 4'b0111, "load");
    apply(1'b0, 1'b0, 4'b1111, "hold");
    apply(1'b0, 1'b1, 4'b1010, "reload");
    apply(1'b1, 1'b1, 4'b0101, "rst_prio");
    apply(1'b0, 1'b0, 4'b0101, "hold_after_rst");
    apply(1'b0, 1'b1, 4'b1000, "neg_min");
    apply(1'b0, 1'b1, 4'b0000, "neg_zero");
    apply(1'b0, 1'b1, 4'b0001, "neg_one");
    apply(1'b0, 1'b1, 4'b0110, "b2b_a");
    apply(1'b0, 1'b1, 4'b1101, "b2b_b");
    apply(1'b0, 1'b0, 4'b0011, "hold_b2b");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic             r;
      logic             c;
      logic [WIDTH-1:0] d;
      r = ($urandom_range(0, 15) == 0);
      c = 1'($urandom_range(0, 1));
      d = WIDTH'($urandom_range(0, MOD - 1));
      apply(r, c, d, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
